param_config_controller: RTL



---
 rtl/param_cfg_pkg.sv | 10 +
 rtl/param_stage_regs.sv | 35 +++
 rtl/param_config_controller.sv | 82 ++++++++
 3 files changed

// File: rtl/param_cfg_pkg.sv
// param_cfg_pkg: shared address map and FSM state type for the parameter config controller
package param_cfg_pkg;
    localparam int CMD_ADDR_SIZE = 3;
    localparam logic [CMD_ADDR_SIZE-1:0] ADDR_ACT    = 3'd0;
    localparam logic [CMD_ADDR_SIZE-1:0] ADDR_DENSE  = 3'd1;
    localparam logic [CMD_ADDR_SIZE-1:0] ADDR_COST   = 3'd2;
    localparam logic [CMD_ADDR_SIZE-1:0] ADDR_LR     = 3'd3;
    localparam logic [CMD_ADDR_SIZE-1:0] ADDR_COMMIT = 3'd4;
    typedef enum logic [1:0] {IDLE, WAIT_IDLE, COMMIT} cfg_state_t;
endpackage

// File: rtl/param_stage_regs.sv
// param_stage_regs: staged parameter fields with per-field dirty bits
module param_stage_regs #(
    parameter int act_type_size      = 4,
    parameter int dense_type_size    = 4,
    parameter int cost_type_size     = 8,
    parameter int learning_rate_size = 16,
    parameter int cmd_data_size      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    wr,
    input  logic [cmd_data_size-1:0]      wr_data,
    input  logic                          clear_dirty,
    output logic [act_type_size-1:0]      act_type,
    output logic [dense_type_size-1:0]    dense_type,
    output logic [cost_type_size-1:0]     cost_type,
    output logic [learning_rate_size-1:0] learning_rate,
    output logic [3:0]                    dirty
);
    always_ff @(posedge clk) begin
        if (reset) begin
            act_type      <= '0;
            dense_type    <= '0;
            cost_type     <= '0;
            learning_rate <= '0;
            dirty         <= '0;
        end else begin
            if (wr[0]) act_type <= wr_data[act_type_size-1:0];
            if (wr[1]) dense_type <= wr_data[dense_type_size-1:0];
            if (wr[2]) cost_type <= wr_data[cost_type_size-1:0];
            if (wr[3]) learning_rate <= wr_data[learning_rate_size-1:0];
            dirty <= (clear_dirty ? 4'b0 : dirty) | wr;
        end
    end
endmodule

// File: rtl/param_config_controller.sv
// param_config_controller: stages host parameter writes and applies them atomically once the datapath is idle
module param_config_controller
    import param_cfg_pkg::*;
#(
    parameter int act_type_size      = 4,
    parameter int dense_type_size    = 4,
    parameter int cost_type_size     = 8,
    parameter int learning_rate_size = 16,
    parameter int cmd_data_size      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CMD_ADDR_SIZE-1:0]      cmd_addr,
    input  logic [cmd_data_size-1:0]      cmd_data,
    input  logic                          dp_busy,
    output logic                          dp_hold,
    output logic [act_type_size-1:0]      in_act_type,
    output logic [dense_type_size-1:0]    in_dense_type,
    output logic [cost_type_size-1:0]     in_cost_type,
    output logic [learning_rate_size-1:0] in_learning_rate,
    output logic                          update_act_type,
    output logic                          update_dense_type,
    output logic                          update_cost_type,
    output logic                          update_learning_rate,
    output logic                          commit_done,
    output logic                          cmd_err
);
    cfg_state_t state, next;
    logic       accept;
    logic [3:0] wr, dirty;
    logic       apply;

    assign accept = cmd_valid && cmd_ready;
    assign wr = {4{accept}} & {cmd_addr == ADDR_LR, cmd_addr == ADDR_COST,
                               cmd_addr == ADDR_DENSE, cmd_addr == ADDR_ACT};

    param_stage_regs #(
        .act_type_size(act_type_size),
        .dense_type_size(dense_type_size),
        .cost_type_size(cost_type_size),
        .learning_rate_size(learning_rate_size),
        .cmd_data_size(cmd_data_size)
    ) u_stage (
        .clk(clk),
        .reset(reset),
        .wr(wr),
        .wr_data(cmd_data),
        .clear_dirty(state == COMMIT),
        .act_type(in_act_type),
        .dense_type(in_dense_type),
        .cost_type(in_cost_type),
        .learning_rate(in_learning_rate),
        .dirty(dirty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cmd_err <= 1'b0;
        end else begin
            state   <= next;
            cmd_err <= accept && (cmd_addr > ADDR_COMMIT);
        end
    end

    always_comb begin
        next = state == IDLE      ? ((accept && cmd_addr == ADDR_COMMIT) ? WAIT_IDLE : IDLE) :
               state == WAIT_IDLE ? (dp_busy ? WAIT_IDLE : COMMIT) : IDLE;
    end

    // Strobes are masked by reset so parameter_storage never latches in a reset cycle
    assign apply                = (state == COMMIT) && !reset;
    assign cmd_ready            = state == IDLE;
    assign dp_hold              = state != IDLE;
    assign commit_done          = apply;
    assign update_act_type      = apply && dirty[0];
    assign update_dense_type    = apply && dirty[1];
    assign update_cost_type     = apply && dirty[2];
    assign update_learning_rate = apply && dirty[3];
endmodule
